// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and lane helpers for the M-stage data-memory access controller.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      WIDTH_WORD = 2'd0,
      WIDTH_HALF = 2'd1,
      WIDTH_BYTE = 2'd2,
      WIDTH_RSVD = 2'd3
   } width_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Reserved width is always rejected; bytes can never be misaligned.
   function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] addrLo);
      logic bad;
      case (width_e'(width))
         WIDTH_WORD: bad = (addrLo != 2'b00);
         WIDTH_HALF: bad = addrLo[0];
         WIDTH_BYTE: bad = 1'b0;
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byteEnables(input logic [1:0] width, input logic [1:0] addrLo);
      logic [3:0] be;
      case (width_e'(width))
         WIDTH_WORD: be = 4'b1111;
         WIDTH_HALF: be = addrLo[1] ? 4'b1100 : 4'b0011;
         WIDTH_BYTE: be = 4'b0001 << addrLo;
         default:    be = '0;
      endcase
      return be;
   endfunction

   // Store data is replicated into every lane so the byte enables alone pick the target.
   function automatic logic [31:0] laneData(input logic [1:0] width, input logic [31:0] wdata);
      logic [31:0] d;
      case (width_e'(width))
         WIDTH_HALF: d = {2{wdata[15:0]}};
         WIDTH_BYTE: d = {4{wdata[7:0]}};
         default:    d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Load lane select and sign/zero extension of a memory read word.
module load_ext
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  op_width,
   input  logic        load_signed,
   output logic [31:0] data
);

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   // Pick the addressed lane and extend it to a full word.
   always_comb begin
      case (addr)
         2'd0:    laneByte = rdata[7:0];
         2'd1:    laneByte = rdata[15:8];
         2'd2:    laneByte = rdata[23:16];
         default: laneByte = rdata[31:24];
      endcase
      laneHalf = addr[1] ? rdata[31:16] : rdata[15:0];
      case (width_e'(op_width))
         WIDTH_BYTE: data = {{24{load_signed & laneByte[7]}}, laneByte};
         WIDTH_HALF: data = {{16{load_signed & laneHalf[15]}}, laneHalf};
         default:    data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: issues one registered request per
// aligned load/store, stalls the pipeline until mem_ack, returns extended load data.
// Optional macro MEM_TIMEOUT_EN adds a WAIT-cycle timeout that aborts with bus_err.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        mem_write,
   input  logic [1:0]  op_width,
   input  logic        load_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall_m,
   output logic [31:0] rdata_out,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic        bus_err
);

   state_e      state;
   state_e      stateNext;
   logic        misaligned;
   logic        issue;
   logic        complete;
   logic        abort;
   logic [1:0]  accWidth;
   logic [1:0]  accAddrLo;
   logic        accSigned;
   logic [31:0] loadData;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] waitCnt;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   // Next-state, pipeline stall and address-error decode.
   always_comb begin
      misaligned = isMisaligned(op_width, addr[1:0]);
      stateNext  = state;
      stall_m    = 1'b0;
      addr_err   = 1'b0;
      issue      = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  addr_err = 1'b1;
               end else begin
                  issue     = 1'b1;
                  stall_m   = 1'b1;
                  stateNext = WAIT;
               end
            end
         end
         WAIT: begin
            stall_m = 1'b1;
            if (mem_ack) begin
               complete  = 1'b1;
               stateNext = DONE;
            end else begin
`ifdef MEM_TIMEOUT_EN
               abort = (waitCnt == CntW'(TIMEOUT_CYCLES - 1));
`endif
               if (abort) stateNext = DONE;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Memory request registers and load result capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
         rdata_out   <= '0;
         rdata_valid <= 1'b0;
         accWidth    <= '0;
         accAddrLo   <= '0;
         accSigned   <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= byteEnables(op_width, addr[1:0]);
            mem_wdata <= laneData(op_width, wdata);
            accWidth  <= op_width;
            accAddrLo <= addr[1:0];
            accSigned <= load_signed;
         end else if (complete) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               rdata_out   <= loadData;
               rdata_valid <= 1'b1;
            end
         end else if (abort) begin
            mem_req   <= 1'b0;
            rdata_out <= '0;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   // WAIT-cycle counter; bus_err marks the DONE cycle that follows an abort.
   always_ff @(posedge clk) begin
      if (!reset) begin
         waitCnt <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= abort;
         if ((state == WAIT) && !mem_ack && !abort) waitCnt <= waitCnt + 1'b1;
         else                                       waitCnt <= '0;
      end
   end
`else
   assign bus_err = 1'b0;
`endif

   load_ext uLoadExt (
      .rdata       (mem_rdata),
      .addr        (accAddrLo),
      .op_width    (accWidth),
      .load_signed (accSigned),
      .data        (loadData)
   );

endmodule
